// File: rtl/packet_reassembler.sv
// Packet reassembler: collects HEAD/BODY/TAIL flits into slots and streams finished packets in completion order.
// Define PACKET_REASSEMBLER_TIMEOUT_EN to reclaim FILLING slots that stay idle for EXPIRE_TIME cycles.
module packet_reassembler #(
   parameter int NUM_ENTRIES     = 8,
   parameter int MAX_NUM_OF_FLIT = 8,
   parameter int EXPIRE_TIME     = 100,
   parameter int PAYLOAD_WIDTH   = 64,
   parameter int PACKET_ID_WIDTH = 8,
   parameter int FLIT_NUM_WIDTH  = 4
) (
   input  logic                       nocclk,
   input  logic                       rst,
   input  logic [1:0]                 in_flittype,
   input  logic [PACKET_ID_WIDTH-1:0] in_packet_id,
   input  logic [FLIT_NUM_WIDTH-1:0]  in_flit_num,
   input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [PAYLOAD_WIDTH-1:0]   out_payload,
   output logic [PACKET_ID_WIDTH-1:0] out_packet_id,
   output logic [FLIT_NUM_WIDTH-1:0]  out_flit_num,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                drop_count,
   output logic [15:0]                timeout_count
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int POS_W = (MAX_NUM_OF_FLIT > 1) ? $clog2(MAX_NUM_OF_FLIT) : 1;
   localparam int CNT_W = $clog2(MAX_NUM_OF_FLIT + 1);

   localparam logic [1:0] FT_NOPE = 2'd0;
   localparam logic [1:0] FT_HEAD = 2'd1;
   localparam logic [1:0] FT_BODY = 2'd2;
   localparam logic [1:0] FT_TAIL = 2'd3;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_FILLING,
      SLOT_COMPLETE,
      SLOT_DRAINING
   } slot_state_t;

   if (NUM_ENTRIES < 2 || NUM_ENTRIES > 32 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("NUM_ENTRIES must be a power of two in 2..32");
   end
   if (EXPIRE_TIME < 1 || MAX_NUM_OF_FLIT < 2) begin : g_bad_limits
      $error("EXPIRE_TIME must be >= 1 and MAX_NUM_OF_FLIT >= 2");
   end

   slot_state_t                state_q  [NUM_ENTRIES];
   slot_state_t                state_d  [NUM_ENTRIES];
   logic [PACKET_ID_WIDTH-1:0] id_q     [NUM_ENTRIES];
   logic [PACKET_ID_WIDTH-1:0] id_d     [NUM_ENTRIES];
   logic [CNT_W-1:0]           cnt_q    [NUM_ENTRIES];
   logic [CNT_W-1:0]           cnt_d    [NUM_ENTRIES];
   logic [PAYLOAD_WIDTH-1:0]   mem      [NUM_ENTRIES][MAX_NUM_OF_FLIT];
   logic [IDX_W-1:0]           fifo_mem [NUM_ENTRIES];

   logic [IDX_W-1:0] wr_ptr, rd_ptr;
   logic [IDX_W:0]   fifo_cnt;
   logic [CNT_W-1:0] rd_pos, rd_pos_d;
   logic [15:0]      drop_q;

   logic             match_any, free_any, accept, touch, seq_ok;
   logic [IDX_W-1:0] match_idx, free_idx, tgt, head_idx;
   logic             wr_en, push, pop, drop;
   logic [IDX_W-1:0] wr_slot;
   logic [POS_W-1:0] wr_pos;

`ifdef PACKET_REASSEMBLER_TIMEOUT_EN
   localparam int TMR_W = $clog2(EXPIRE_TIME + 1);
   logic [TMR_W-1:0] tmr_q [NUM_ENTRIES];
   logic [TMR_W-1:0] tmr_d [NUM_ENTRIES];
   logic [15:0]      timeout_q;
   int               expire_n;
   int               timeout_sum;
`endif

   // Slot lookup: scanning downward leaves the lowest matching/free index selected.
   always_comb begin : lookup
      match_any = 1'b0;
      match_idx = '0;
      free_any  = 1'b0;
      free_idx  = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] == SLOT_FILLING && id_q[i] == in_packet_id) begin
            match_any = 1'b1;
            match_idx = IDX_W'(i);
         end
         if (state_q[i] == SLOT_FREE) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign in_ready = !(in_flittype == FT_HEAD && !match_any && !free_any);
   assign accept   = in_valid && in_ready;
   assign touch    = accept && match_any && (in_flittype != FT_NOPE);
   assign seq_ok   = (32'(in_flit_num) == 32'(cnt_q[match_idx]))
                     && (cnt_q[match_idx] < CNT_W'(MAX_NUM_OF_FLIT));

   assign head_idx      = fifo_mem[rd_ptr];
   assign out_valid     = (fifo_cnt != '0);
   assign out_payload   = mem[head_idx][POS_W'(rd_pos)];
   assign out_packet_id = id_q[head_idx];
   assign out_flit_num  = FLIT_NUM_WIDTH'(rd_pos);
   assign out_last      = out_valid && ((rd_pos + CNT_W'(1)) == cnt_q[head_idx]);
   assign pop           = out_valid && out_ready && out_last;

   always_comb begin : next_state
      // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
      state_d  = state_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      rd_pos_d = rd_pos;
      wr_en    = 1'b0;
      wr_slot  = '0;
      wr_pos   = '0;
      push     = 1'b0;
      drop     = 1'b0;
      tgt      = match_any ? match_idx : free_idx;
`ifdef PACKET_REASSEMBLER_TIMEOUT_EN
      tmr_d    = tmr_q;
      expire_n = 0;
`endif

      // Drain side only ever touches the FIFO head, which is COMPLETE or DRAINING.
      if (out_valid && out_ready) begin
         if (out_last) begin
            state_d[head_idx] = SLOT_FREE;
            rd_pos_d          = '0;
         end else begin
            state_d[head_idx] = SLOT_DRAINING;
            rd_pos_d          = rd_pos + CNT_W'(1);
         end
      end

`ifdef PACKET_REASSEMBLER_TIMEOUT_EN
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (state_q[i] == SLOT_FILLING && !(touch && match_idx == IDX_W'(i))) begin
            if (tmr_q[i] == TMR_W'(EXPIRE_TIME - 1)) begin
               state_d[i] = SLOT_FREE;
               expire_n++;
            end else begin
               tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end
         end
      end
`endif

      if (accept) begin
         case (in_flittype)
            FT_HEAD: begin
               drop = match_any || (in_flit_num != '0);
               if (in_flit_num != '0) begin
                  if (match_any) state_d[match_idx] = SLOT_FREE;
               end else begin
                  state_d[tgt] = SLOT_FILLING;
                  id_d[tgt]    = in_packet_id;
                  cnt_d[tgt]   = CNT_W'(1);
                  wr_en        = 1'b1;
                  wr_slot      = tgt;
`ifdef PACKET_REASSEMBLER_TIMEOUT_EN
                  tmr_d[tgt]   = '0;
`endif
               end
            end
            FT_BODY, FT_TAIL: begin
               if (!match_any) begin
                  drop = 1'b1;
               end else if (seq_ok) begin
                  cnt_d[match_idx] = cnt_q[match_idx] + CNT_W'(1);
                  wr_en            = 1'b1;
                  wr_slot          = match_idx;
                  wr_pos           = POS_W'(in_flit_num);
`ifdef PACKET_REASSEMBLER_TIMEOUT_EN
                  tmr_d[match_idx] = '0;
`endif
                  if (in_flittype == FT_TAIL) begin
                     state_d[match_idx] = SLOT_COMPLETE;
                     push               = 1'b1;
                  end
               end else begin
                  state_d[match_idx] = SLOT_FREE;
                  drop               = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge nocclk) begin : storage
      // NOTE: payload, id/count and FIFO storage are not reset; each entry is written before the state machine exposes it.
      id_q  <= id_d;
      cnt_q <= cnt_d;
      if (wr_en) mem[wr_slot][wr_pos] <= in_payload;
      if (push)  fifo_mem[wr_ptr] <= match_idx;
   end

   always_ff @(posedge nocclk) begin : control
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= SLOT_FREE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         rd_pos   <= '0;
         drop_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_pos  <= rd_pos_d;
         if (push) wr_ptr <= wr_ptr + IDX_W'(1);
         if (pop)  rd_ptr <= rd_ptr + IDX_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (IDX_W+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (IDX_W+1)'(1);
            default: ;
         endcase
         if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

   assign drop_count = drop_q;

`ifdef PACKET_REASSEMBLER_TIMEOUT_EN
   assign timeout_sum = int'(timeout_q) + expire_n;

   always_ff @(posedge nocclk) begin : timers
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) tmr_q[i] <= '0;
         timeout_q <= '0;
      end else begin
         tmr_q     <= tmr_d;
         timeout_q <= (timeout_sum > 65535) ? 16'hFFFF : timeout_sum[15:0];
      end
   end

   assign timeout_count = timeout_q;
`else
   assign timeout_count = 16'd0;
`endif

endmodule
